// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin merge of NUM_CHANNELS AXI-stream sources into one registered output.
// Define AXIS_PACKET_ARBITER_STATS_EN to add per-channel completed-packet counters (pkt_count, stats_clear).
module axis_packet_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int CHWIDTH      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CHANNELS*DWIDTH-1:0] s_data,
  input  logic [NUM_CHANNELS-1:0]        s_valid,
  input  logic [NUM_CHANNELS-1:0]        s_last,
  output logic [NUM_CHANNELS-1:0]        s_ready,
  output logic [DWIDTH-1:0]              m_data,
  output logic                           m_valid,
  output logic                           m_last,
  output logic [CHWIDTH-1:0]             m_channel,
  input  logic                           m_ready
`ifdef AXIS_PACKET_ARBITER_STATS_EN
  ,
  input  logic                           stats_clear,
  output logic [NUM_CHANNELS*32-1:0]     pkt_count
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]         state;
  logic [CHWIDTH-1:0] rr_ptr;
  logic [CHWIDTH-1:0] grant;
  logic [CHWIDTH-1:0] sel;
  logic [CHWIDTH-1:0] cur;
  logic               sel_found;
  logic               active;
  logic               load_en;
  logic               xfer;

  logic [DWIDTH-1:0]  data_p1;
  logic               last_p1;
  logic               vld_p1;
  logic [CHWIDTH-1:0] chan_p1;

  function automatic logic [CHWIDTH-1:0] wrap_idx(input logic [CHWIDTH-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NUM_CHANNELS) t = t - NUM_CHANNELS;
    return t[CHWIDTH-1:0];
  endfunction

  assign load_en = ~vld_p1 | m_ready;

  // Round-robin search starting at rr_ptr; first valid channel wins.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!sel_found && s_valid[wrap_idx(rr_ptr, k)]) begin
        sel       = wrap_idx(rr_ptr, k);
        sel_found = 1'b1;
      end
    end
  end

  assign cur    = (state == LOCK) ? grant : sel;
  assign active = (state == LOCK) | sel_found;
  assign xfer   = active & load_en & s_valid[cur];

  always_comb begin
    s_ready      = '0;
    s_ready[cur] = active & load_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else if (xfer) begin
      if (s_last[cur]) begin
        state  <= IDLE;
        rr_ptr <= wrap_idx(cur, 1);
      end else begin
        state <= LOCK;
        grant <= cur;
      end
    end
  end

  // Stage p1: single output register, loaded whenever it is empty or being drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      chan_p1 <= '0;
    end else if (load_en) begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= s_data[int'(cur)*DWIDTH +: DWIDTH];
        last_p1 <= s_last[cur];
        chan_p1 <= cur;
      end
    end
  end

  assign m_data    = data_p1;
  assign m_last    = last_p1;
  assign m_valid   = vld_p1;
  assign m_channel = chan_p1;

`ifdef AXIS_PACKET_ARBITER_STATS_EN
  logic        xfer_last;
  logic [31:0] cnt [NUM_CHANNELS];

  assign xfer_last = xfer & s_last[cur];

  // Clear takes priority over a same-cycle packet completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (stats_clear)
          cnt[i] <= '0;
        else if (xfer_last && (cur == CHWIDTH'(i)))
          cnt[i] <= cnt[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pack
    assign pkt_count[g*32 +: 32] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed + randomized scoreboard bench for axis_packet_arbiter (4 channels, 32-bit data).
// Covers the AXIS_PACKET_ARBITER_STATS_EN counters when that macro is defined.
module tb_axis_packet_arbiter;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH*DW-1:0] s_data = '0;
  logic [NCH-1:0]    s_valid = '0;
  logic [NCH-1:0]    s_last = '0;
  logic [NCH-1:0]    s_ready;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_last;
  logic [CHW-1:0]    m_channel;
  logic              m_ready = 1'b1;
`ifdef AXIS_PACKET_ARBITER_STATS_EN
  logic              stats_clear = 1'b0;
  logic [NCH*32-1:0] pkt_count;
`endif

  axis_packet_arbiter #(.DWIDTH(DW), .NUM_CHANNELS(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_channel (m_channel),
    .m_ready   (m_ready)
`ifdef AXIS_PACKET_ARBITER_STATS_EN
    ,
    .stats_clear (stats_clear),
    .pkt_count   (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW:0] src_q [NCH][$];
  logic [DW:0] exp_q [NCH][$];
  int          order_q [$];
  logic [NCH-1:0] en = '0;
  bit  rand_ready = 1'b0;
  bit  rand_valid = 1'b0;
  int  first_fire_cyc = -1;
  int  first_out_cyc  = -1;
  int  last_out_cyc   = -1;
  int  out_beats      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_pkt(input int ch, input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) begin
      src_q[ch].push_back({(i == len - 1), base + DW'(i)});
      exp_q[ch].push_back({(i == len - 1), base + DW'(i)});
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = 1'b1;
      for (int c = 0; c < NCH; c++)
        if (src_q[c].size() != 0 || exp_q[c].size() != 0) done = 1'b0;
    end
    check(tag, done, 1);
  endtask

  task automatic check_order(input string tag, input int expo [$]);
    check({tag, "_count"}, order_q.size(), expo.size());
    for (int i = 0; i < expo.size(); i++)
      if (i < order_q.size()) check(tag, order_q[i], expo[i]);
  endtask

  // Source driver: pops beats accepted on the previous edge, presents the next ones.
  always begin
    logic [NCH-1:0] fire;
    @(negedge clk);
    fire = reset ? '0 : (s_valid & s_ready);
    if (fire != '0 && first_fire_cyc < 0) first_fire_cyc = cyc;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (fire[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      if (!reset && en[c] && src_q[c].size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        s_valid[c]         = 1'b1;
        s_data[c*DW +: DW] = src_q[c][0][DW-1:0];
        s_last[c]          = src_q[c][0][DW];
      end else begin
        s_valid[c]         = 1'b0;
        s_data[c*DW +: DW] = '0;
        s_last[c]          = 1'b0;
      end
    end
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: per-channel scoreboard plus hold-under-backpressure check.
  logic [DW-1:0]  prev_data;
  logic           prev_last;
  logic [CHW-1:0] prev_ch;
  bit             prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [DW:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
        check("hold_chan", m_channel, prev_ch);
      end
      if (m_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (m_valid && m_ready) begin
        out_beats++;
        last_out_cyc = cyc;
        check("sb_nonempty", exp_q[m_channel].size() != 0, 1);
        if (exp_q[m_channel].size() != 0) begin
          e = exp_q[m_channel].pop_front();
          check("sb_data", m_data, e[DW-1:0]);
          check("sb_last", m_last, e[DW]);
        end
        if (m_last) order_q.push_back(int'(m_channel));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_ch    = m_channel;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_channel", m_channel, 0);
    check("rst_s_ready", s_ready, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single 5-beat packet on channel 2
    first_fire_cyc = -1; first_out_cyc = -1; out_beats = 0; order_q.delete();
    send_pkt(2, 5, 32'd0);
    en = 4'b0100;
    wait_drain("t1_drain", 60);
    check("t1_latency", first_out_cyc - first_fire_cyc, 1);
    check("t1_span", last_out_cyc - first_out_cyc, 4);
    check("t1_beats", out_beats, 5);
    check_order("t1_order", '{2});

    // Reset to restart arbitration at channel 0, then 3 channels x 2 packets back-to-back
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst2_m_valid", m_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    en = 4'b0000;
    first_out_cyc = -1; order_q.delete();
    for (int p = 0; p < 2; p++) begin
      send_pkt(0, 3, 32'h0000_0100 + 32'(p * 16));
      send_pkt(1, 3, 32'h0000_1100 + 32'(p * 16));
      send_pkt(3, 3, 32'h0000_3100 + 32'(p * 16));
    end
    en = 4'b1011;
    wait_drain("t2_drain", 100);
    check_order("t2_order", '{0, 1, 3, 0, 1, 3});
    check("t2_no_bubbles", last_out_cyc - first_out_cyc, 17);

    // Channel 1 locked mid-packet while channels 0 and 3 request
    en = 4'b0000; order_q.delete();
    send_pkt(1, 4, 32'hA100);
    en = 4'b0010;
    n = 0;
    while (src_q[1].size() > 2 && n < 50) begin @(negedge clk); n++; end
    check("t3_midpkt_reached", src_q[1].size() <= 2, 1);
    send_pkt(0, 2, 32'hA000);
    send_pkt(3, 2, 32'hA300);
    en = 4'b1011;
    n = 0;
    while (src_q[1].size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
      if (src_q[1].size() > 0) begin
        check("t3_ready0_locked", s_ready[0], 0);
        check("t3_ready3_locked", s_ready[3], 0);
      end
    end
    wait_drain("t3_drain", 100);
    check_order("t3_order", '{1, 3, 0});

    // Random backpressure and source gaps, 4 channels x 100 packets
    en = 4'b0000; order_q.delete();
    for (int p = 0; p < 100; p++)
      for (int c = 0; c < NCH; c++)
        send_pkt(c, int'($urandom_range(1, 6)), $urandom);
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    en = 4'b1111;
    wait_drain("t4_drain", 30000);
    rand_ready = 1'b0;
    rand_valid = 1'b0;
    check("t4_pkts", order_q.size(), 400);

    // Point rr_ptr at channel 2, then reset during beat 3 of a 6-beat channel-2 packet
    en = 4'b0000; order_q.delete();
    send_pkt(1, 2, 32'hB100);
    en = 4'b0010;
    wait_drain("t5_pre_drain", 50);
    send_pkt(2, 6, 32'hC200);
    en = 4'b0100;
    n = 0;
    while (src_q[2].size() > 4 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    check("t5_pre_valid", m_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_last", m_last, 0);
    check("t5_rst_chan", m_channel, 0);
    check("t5_rst_data", m_data, 0);
    @(posedge clk);
    #2;
    en = 4'b0000;
    for (int c = 0; c < NCH; c++) begin src_q[c].delete(); exp_q[c].delete(); end
    order_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    send_pkt(1, 3, 32'hD100);
    send_pkt(2, 3, 32'hD200);
    en = 4'b0110;
    wait_drain("t5_drain", 60);
    check_order("t5_order", '{1, 2});

`ifdef AXIS_PACKET_ARBITER_STATS_EN
    en = 4'b0000;
    @(negedge clk);
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    check("st_cleared0", pkt_count[31:0], 0);
    for (int p = 0; p < 7; p++) send_pkt(0, 2, 32'hE000 + 32'(p * 4));
    for (int p = 0; p < 3; p++) send_pkt(3, 1, 32'hE300 + 32'(p));
    en = 4'b1001;
    wait_drain("st_drain", 100);
    check("st_count0", pkt_count[31:0], 7);
    check("st_count1", pkt_count[63:32], 0);
    check("st_count3", pkt_count[127:96], 3);
    send_pkt(0, 1, 32'hEF00);
    n = 0;
    while (!(s_valid[0] && s_ready[0]) && n < 20) begin @(negedge clk); n++; end
    check("st_last_seen", s_valid[0] && s_ready[0], 1);
    stats_clear = 1'b1;
    @(posedge clk);
    #1;
    stats_clear = 1'b0;
    @(negedge clk);
    check("st_clear_wins0", pkt_count[31:0], 0);
    check("st_clear_wins3", pkt_count[127:96], 0);
    wait_drain("st_drain2", 50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- N-channel packetized AXI-stream arbiter: merges NUM_CHANNELS Master_Full-style sources into one Master_Full output.
- Round-robin grant at packet granularity. A granted channel holds the output until its `last` beat.
- Emits the source channel index alongside each beat.
- Sits between per-channel capture/packetizer blocks and the shared DMA readout path.

Parameters:
- DWIDTH, 32, data width per channel and of the output.
- NUM_CHANNELS, 4, number of input streams; must be >= 1.
- CHWIDTH, (NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1), width of the channel index.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- s_data  input  NUM_CHANNELS*DWIDTH  channel i data at [i*DWIDTH +: DWIDTH]
- s_valid  input  NUM_CHANNELS  per-channel valid
- s_last  input  NUM_CHANNELS  per-channel end of packet
- s_ready  output  NUM_CHANNELS  per-channel ready (combinational)
- m_data  output  DWIDTH  merged data (registered)
- m_valid  output  1  merged valid (registered)
- m_last  output  1  merged last (registered)
- m_channel  output  CHWIDTH  source channel of the current beat (registered)
- m_ready  input  1  downstream ready

Behaviour:
- Reset values (asynchronous, active-high):
  - m_valid=0, m_data=0, m_last=0, m_channel=0.
  - state=IDLE, rr_ptr=0, grant=0.
- Transfer rules:
  - Input transfer on channel i when s_valid[i] & s_ready[i].
  - Output transfer when m_valid & m_ready.
- Output stage: single register. load_en = ~m_valid | m_ready.
  - On a load, capture data/last of the transferring channel, m_channel = its index, m_valid=1.
  - If load_en and no input transfer occurs, m_valid=0.
  - m_data/m_last/m_channel hold when not loaded.
- Latency: 1 cycle from input transfer to m_valid. Full throughput of 1 beat/cycle while m_ready=1.
- State machine (2 states):
  - IDLE:
    - sel = first i with s_valid[i]=1, searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_CHANNELS.
    - s_ready[sel]=load_en; all other s_ready=0.
    - If the beat transfers with s_last=0: grant<=sel, go LOCK.
    - If it transfers with s_last=1 (single-beat packet): stay IDLE, rr_ptr<=(sel+1) mod NUM_CHANNELS.
    - No valid channel: all s_ready=0, rr_ptr unchanged.
  - LOCK:
    - s_ready[grant]=load_en; all others 0, even if their valid is high.
    - Beat transferred with s_last=1: go IDLE, rr_ptr<=(grant+1) mod NUM_CHANNELS.
    - s_valid[grant] low mid-packet: stay LOCK, output bubbles. No timeout.
- s_ready never depends on s_valid of the same channel in LOCK; in IDLE it depends on all s_valid (combinational priority).
- rr_ptr wrap: from NUM_CHANNELS-1 to 0.
- NUM_CHANNELS=1: degenerate pass-through with register; m_channel always 0.
- Backpressure: m_ready=0 with m_valid=1 gives all s_ready=0; state and rr_ptr frozen.
- Reset mid-packet: packet is truncated (no m_last emitted); after reset, arbitration restarts at channel 0.
- s_data/s_last of non-granted channels are ignored.

Optional Feature:
- Macro: AXIS_PACKET_ARBITER_STATS_EN.
- Defined:
  - Adds output port pkt_count, NUM_CHANNELS*32, plus input port stats_clear, 1.
  - pkt_count[i*32 +: 32] increments on each channel-i input transfer with s_last=1. Wraps 2^32-1 -> 0.
  - stats_clear=1 zeroes all counters next cycle; clear wins over a simultaneous increment.
  - Reset value 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single channel 2 streams packet of 5 beats (0..4), m_ready=1 -> m_data 0..4 on 5 consecutive cycles, m_last only on beat 4, m_channel=2, first m_valid 1 cycle after first s transfer.
- Channels 0,1,3 all valid with 3-beat packets continuously, m_ready=1 -> packet order 0,1,3,0,1,3; no interleaving within a packet; no bubbles between packets.
- Channel 1 mid-packet (beat 2 of 4) while channel 0 asserts valid -> s_ready[0]=0 until channel 1 last transfers; next packet is channel 3 if valid, else 0 (rr_ptr=2 search).
- Random m_ready toggling (do_readout with rand_ready), 4 channels x 100 random-length packets -> scoreboard per channel matches exactly, m_data stable while m_valid & ~m_ready.
- Assert reset during beat 3 of a 6-beat channel-2 packet -> m_valid=0 immediately, state IDLE; subsequent channel 1 and 2 packets arbitrate starting from channel 0 search.
- STATS_EN: 7 packets on channel 0, 3 on channel 3 -> pkt_count[0]=7, [3]=3; stats_clear pulse coinciding with a last beat -> count reads 0.
